multicycle_control_hs: RTL and testbench
========================================

Name: multicycle_control_hs

Overview:
Parametrised next-generation multicycle control FSM for the core datapath.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction.
- Latches the opcode once per instruction and drives datapath strobes.
- Adds a memory request/acknowledge handshake with timeout, a run/stall input, BLQZ branch PC load, HALT, and illegal-opcode detection.
- Sits between instruction memory output and the register file / ALU / data memory / PC.

Parameters:
OP_W, 4, opcode width; must be >= 4 so that HALT is encodable.
MEM_TIMEOUT, 16, maximum MEM-state cycles without mem_ack before the fault; must be >= 2.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  allows FETCH to advance; when low, the FSM stalls in FETCH
instruction  in  OP_W  opcode field from instruction memory; sampled in DECODE only
branch_cond  in  1  datapath "less-or-equal zero" flag; sampled in WRITEBACK
mem_ack  in  1  data memory completion, valid in MEM only
alu_op  out  OP_W  latched opcode
next_ins  out  1  PC increment strobe
immediate  out  1  selects immediate operand
reg_write  out  1  register file write enable
mem_req  out  1  data memory request
mem_write  out  1  data memory write enable
mem_to_reg  out  1  writeback mux selects memory data
pc_load  out  1  PC loads branch target
illegal_op  out  1  one-cycle pulse on an undefined opcode
halted  out  1  FSM in HALTED or FAULT
mem_timeout  out  1  sticky; set on memory timeout
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset, synchronous on the clock edge while reset is high:
  - state=FETCH, op_q=0, wait counter=0, mem_timeout=0.
  - While reset is high, all outputs are forced to 0.
- Outputs are Moore-style: a function of state, op_q and (for next_ins) run only. There is no combinational path from instruction, mem_ack or branch_cond to any output, except pc_load from branch_cond in WRITEBACK.
- alu_op = op_q in every state.
- Opcode map (OP_W=4): ADD=0, XOR=1, AND=2, RSL=3, MOV=4, LD=5, ST=6, BLQZ=7, HALT=15. Codes 8..14 are illegal.
- FETCH:
  - next_ins = run.
  - If run=1, go to DECODE; otherwise stay.
- DECODE:
  - op_q <= instruction.
  - Go to EXECUTE. No strobes.
- EXECUTE:
  - immediate=1 for RSL, MOV, BLQZ.
  - Next state: LD/ST -> MEM, counter cleared; HALT -> HALTED; illegal -> FETCH with illegal_op=1 this cycle (instruction acts as NOP); otherwise -> WRITEBACK.
- MEM:
  - mem_req=1; mem_write=1 if ST; mem_to_reg=1 if LD.
  - Counter increments each cycle.
  - mem_ack=1 -> WRITEBACK. An ack takes priority over timeout in the same cycle.
  - Otherwise, if counter == MEM_TIMEOUT-1 -> FAULT and set mem_timeout.
- WRITEBACK:
  - reg_write=1 for ADD, XOR, AND, RSL, MOV, LD.
  - mem_to_reg=1 for LD.
  - pc_load = branch_cond when op_q==BLQZ.
  - ST writes nothing.
  - Go to FETCH.
- HALTED and FAULT:
  - halted=1; all other strobes 0.
  - Only reset exits.
- Latency:
  - Non-memory instructions: 4 cycles, FETCH through WRITEBACK.
  - LD/ST: 4+N cycles, where N>=1 is the number of MEM cycles including the ack cycle.
  - Each stalled FETCH cycle adds 1.
- run only gates FETCH. A run drop mid-instruction has no effect until the next FETCH.
- Reset mid-MEM: mem_req drops in the cycle reset is sampled high; no write completes.
- Instruction changes outside DECODE are ignored.
- The counter is clog2(MEM_TIMEOUT) bits wide and saturates; it never wraps.

Decomposition:
- Shared package definitions:
  - opcode constants ADD..BLQZ and HALT at OP_W width.
  - state enum: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALTED=5, FAULT=6, 3-bit.
  - helper function is_legal_op.
- One sub-module: ctrl_decode. It is combinational and maps (state, op_q, run, branch_cond) to the strobe vector. The top holds the state register, op_q, counter and sticky flag.

Test Plan:
1. ADD with run=1, mem_ack=0 -> state sequence 0,1,2,4,0. next_ins high 1 cycle; reg_write high exactly in cycle 4; immediate never high.
2. LD, ack after 3 MEM cycles -> mem_req high 3 cycles with mem_to_reg=1; reg_write+mem_to_reg in WB; total 7 cycles. ST, same timing -> mem_write high 3 cycles, reg_write never high.
3. BLQZ with branch_cond=1 -> immediate in EXECUTE, pc_load=1 in WB, reg_write=0. Repeat with branch_cond=0 -> pc_load=0.
4. ST with mem_ack held 0 (MEM_TIMEOUT=16) -> FAULT after 16 MEM cycles; mem_timeout=1, halted=1, no further next_ins. Separately, ack on the 16th cycle -> WRITEBACK, no fault.
5. Opcode 9 -> illegal_op pulse in EXECUTE, then FETCH, no strobes. HALT(15) -> halted=1 persists for 20 cycles with run=1; reset returns to FETCH.
6. run=0 for 5 cycles at FETCH -> state_o stays 0, next_ins=0. Reset asserted in MEM -> next cycle all outputs 0, state FETCH.

Source files
------------

// File: rtl/multicycle_control_hs_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_hs_pkg
// Shared definitions for the multicycle control FSM:
//   - opcode constants (ADD..BLQZ, HALT) as plain integers, so that each
//     module can size them to its own OP_W
//   - state_t   : 3-bit FSM state encoding, also exported on state_o
//   - strobes_t : datapath strobe bundle produced by the decoder
//   - is_legal_op : true for the defined opcodes 0..7 and HALT
// ---------------------------------------------------------------------------
package multicycle_control_hs_pkg;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_XOR  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_RSL  = 3;
  localparam int unsigned OP_MOV  = 4;
  localparam int unsigned OP_LD   = 5;
  localparam int unsigned OP_ST   = 6;
  localparam int unsigned OP_BLQZ = 7;
  localparam int unsigned OP_HALT = 15;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5,
    FAULT     = 3'd6
  } state_t;

  typedef struct packed {
    logic next_ins;
    logic immediate;
    logic reg_write;
    logic mem_req;
    logic mem_write;
    logic mem_to_reg;
    logic pc_load;
    logic illegal_op;
    logic halted;
  } strobes_t;

  // Callers zero-extend the opcode to 32 bits so one helper serves any OP_W.
  function automatic logic is_legal_op(input logic [31:0] op);
    return (op <= 32'(OP_BLQZ)) || (op == 32'(OP_HALT));
  endfunction

endpackage

// File: rtl/multicycle_control_hs_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_hs_if
// Bundles the control FSM's instruction/datapath/memory-handshake signals.
//   slave  : the FSM side (consumes run/instruction/flags, drives strobes)
//   master : the environment side (datapath, memories, sequencer)
// Inputs to the FSM : run, instruction, branch_cond, mem_ack
// Outputs           : alu_op, next_ins, immediate, reg_write, mem_req,
//                     mem_write, mem_to_reg, pc_load, illegal_op, halted,
//                     mem_timeout, state_o
// ---------------------------------------------------------------------------
interface multicycle_control_hs_if #(
  parameter int OP_W = 4
);

  logic            run;
  logic [OP_W-1:0] instruction;
  logic            branch_cond;
  logic            mem_ack;

  logic [OP_W-1:0] alu_op;
  logic            next_ins;
  logic            immediate;
  logic            reg_write;
  logic            mem_req;
  logic            mem_write;
  logic            mem_to_reg;
  logic            pc_load;
  logic            illegal_op;
  logic            halted;
  logic            mem_timeout;
  logic [2:0]      state_o;

  modport slave (
    input  run, instruction, branch_cond, mem_ack,
    output alu_op, next_ins, immediate, reg_write, mem_req, mem_write,
           mem_to_reg, pc_load, illegal_op, halted, mem_timeout, state_o
  );

  modport master (
    output run, instruction, branch_cond, mem_ack,
    input  alu_op, next_ins, immediate, reg_write, mem_req, mem_write,
           mem_to_reg, pc_load, illegal_op, halted, mem_timeout, state_o
  );

endinterface

// File: rtl/multicycle_control_hs_ctrl_decode.sv
// ---------------------------------------------------------------------------
// multicycle_control_hs_ctrl_decode
// Purely combinational strobe decoder for the multicycle control FSM.
// Ports:
//   state       in  current FSM state
//   op_q        in  opcode latched during DECODE
//   run         in  run/stall input (only matters in FETCH)
//   branch_cond in  datapath <=0 flag (only matters in WRITEBACK for BLQZ)
//   strobes     out datapath strobe bundle
// ---------------------------------------------------------------------------
module multicycle_control_hs_ctrl_decode
  import multicycle_control_hs_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  state_t          state,
  input  logic [OP_W-1:0] op_q,
  input  logic            run,
  input  logic            branch_cond,
  output strobes_t        strobes
);

  logic [31:0] op_ext;

  assign op_ext = 32'(op_q);

  // Strobes are a function of state and latched opcode only; run and
  // branch_cond each reach the outputs in exactly one state.
  always_comb begin
    strobes = '0;
    case (state)
      FETCH: begin
        strobes.next_ins = run;
      end
      EXECUTE: begin
        strobes.immediate  = (op_ext == 32'(OP_RSL)) || (op_ext == 32'(OP_MOV)) ||
                             (op_ext == 32'(OP_BLQZ));
        strobes.illegal_op = !is_legal_op(op_ext);
      end
      MEM: begin
        strobes.mem_req    = 1'b1;
        strobes.mem_write  = (op_ext == 32'(OP_ST));
        strobes.mem_to_reg = (op_ext == 32'(OP_LD));
      end
      WRITEBACK: begin
        // ADD..LD all occupy the contiguous codes 0..5 and all write a register.
        strobes.reg_write  = (op_ext <= 32'(OP_LD));
        strobes.mem_to_reg = (op_ext == 32'(OP_LD));
        strobes.pc_load    = (op_ext == 32'(OP_BLQZ)) && branch_cond;
      end
      HALTED, FAULT: begin
        strobes.halted = 1'b1;
      end
      default: begin
        strobes = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_hs.sv
// ---------------------------------------------------------------------------
// multicycle_control_hs
// Multicycle control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK,
// with a memory request/acknowledge handshake guarded by a timeout, a
// run/stall input in FETCH, BLQZ PC load, HALT and illegal-opcode detection.
// Parameters:
//   OP_W        opcode width (>= 4 so HALT is encodable)
//   MEM_TIMEOUT max MEM cycles without mem_ack before FAULT (>= 2)
// Ports:
//   clock  in  rising-edge clock
//   reset  in  synchronous active-high reset; also forces all outputs to 0
//   bus    slave side of multicycle_control_hs_if (inputs run, instruction,
//          branch_cond, mem_ack; strobes, alu_op, halted, mem_timeout,
//          state_o out)
// ---------------------------------------------------------------------------
module multicycle_control_hs
  import multicycle_control_hs_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  multicycle_control_hs_if.slave  bus
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [31:0]     op_ext;
  strobes_t        strobes;

  assign op_ext = 32'(op_q);

  // Next-state logic: opcode captured only in DECODE, wait counter only
  // runs in MEM, and the timeout flag is sticky until reset.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      FETCH: begin
        if (bus.run) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        op_d    = bus.instruction;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        if ((op_ext == 32'(OP_LD)) || (op_ext == 32'(OP_ST))) begin
          state_d = MEM;
          cnt_d   = '0;
        end else if (op_ext == 32'(OP_HALT)) begin
          state_d = HALTED;
        end else if (!is_legal_op(op_ext)) begin
          state_d = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEM: begin
        // Saturating so the counter can never wrap back into a "young" value.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // An ack arriving on the final allowed cycle still wins over the fault.
        if (bus.mem_ack) begin
          state_d = WRITEBACK;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = FAULT;
          timeout_d = 1'b1;
        end
      end
      WRITEBACK: begin
        state_d = FETCH;
      end
      HALTED, FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State, opcode, wait counter and sticky timeout registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      op_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  multicycle_control_hs_ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .state       (state_q),
    .op_q        (op_q),
    .run         (bus.run),
    .branch_cond (bus.branch_cond),
    .strobes     (strobes)
  );

  // Outputs are held at zero for as long as reset is high, so a memory
  // request is withdrawn in the very cycle reset is applied.
  always_comb begin
    bus.alu_op      = '0;
    bus.next_ins    = 1'b0;
    bus.immediate   = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.pc_load     = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.halted      = 1'b0;
    bus.mem_timeout = 1'b0;
    bus.state_o     = 3'd0;
    if (!reset) begin
      bus.alu_op      = op_q;
      bus.next_ins    = strobes.next_ins;
      bus.immediate   = strobes.immediate;
      bus.reg_write   = strobes.reg_write;
      bus.mem_req     = strobes.mem_req;
      bus.mem_write   = strobes.mem_write;
      bus.mem_to_reg  = strobes.mem_to_reg;
      bus.pc_load     = strobes.pc_load;
      bus.illegal_op  = strobes.illegal_op;
      bus.halted      = strobes.halted;
      bus.mem_timeout = timeout_q;
      bus.state_o     = state_q;
    end
  end

endmodule

// File: tb/tb_multicycle_control_hs.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_hs
// Scoreboard bench: each issued instruction pushes its expected per-
// instruction outcome (latency, strobe cycle counts, end condition) derived
// from the instruction-level rules; a monitor summarises what the DUT does
// for each instruction and compares against the head of the queue.
// ---------------------------------------------------------------------------
module tb_multicycle_control_hs;

  localparam int OP_W    = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    int op;
    int stalls;
    int latency;
    int next_ins_c;
    int imm_c;
    int mem_req_c;
    int mem_write_c;
    int mem_to_reg_c;
    int reg_write_c;
    int pc_load_c;
    int illegal_c;
    int halted_end;
    int timeout_end;
  } rec_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   pre_stalls;
  int   rec_idx;
  rec_t exp_q[$];

  multicycle_control_hs_if #(.OP_W(OP_W)) bus ();

  multicycle_control_hs #(
    .OP_W        (OP_W),
    .MEM_TIMEOUT (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hang guard: a stuck bench reports a failure instead of running forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [OP_W-1:0] rop();
    return OP_W'($urandom_range(0, 15));
  endfunction

  function automatic int out_vec();
    return int'({bus.alu_op, bus.next_ins, bus.immediate, bus.reg_write, bus.mem_req,
                 bus.mem_write, bus.mem_to_reg, bus.pc_load, bus.illegal_op, bus.halted,
                 bus.mem_timeout, bus.state_o});
  endfunction

  // Instruction-level expectations: how long each class of instruction
  // takes and how many cycles each strobe should be seen.
  function automatic rec_t model(int op, int stalls, int n, logic bc, logic fault);
    rec_t r;
    int   cyc;
    r = '{default: 0};
    r.op = op;
    r.stalls = stalls;
    r.next_ins_c = 1;
    if (op == 3 || op == 4 || op == 7) r.imm_c = 1;
    if (!(op <= 7 || op == 15)) begin
      r.latency = 3;
      r.illegal_c = 1;
    end else if (op == 15) begin
      r.latency = 4;
      r.halted_end = 1;
    end else if (op == 5 || op == 6) begin
      cyc = fault ? TIMEOUT : n;
      r.mem_req_c = cyc;
      if (op == 6) r.mem_write_c = cyc;
      if (op == 5) r.mem_to_reg_c = cyc;
      if (fault) begin
        r.latency = 3 + cyc + 1;
        r.halted_end = 1;
        r.timeout_end = 1;
      end else begin
        r.latency = 4 + cyc;
        if (op == 5) begin
          r.reg_write_c = 1;
          r.mem_to_reg_c = r.mem_to_reg_c + 1;
        end
      end
    end else begin
      r.latency = 4;
      if (op <= 4) r.reg_write_c = 1;
      if (op == 7 && bc) r.pc_load_c = 1;
    end
    return r;
  endfunction

  // Drive one cycle's worth of inputs, then move to just after the next edge.
  task automatic step(input logic r, input logic [OP_W-1:0] ins, input logic ack, input logic bc);
    bus.run = r;
    bus.instruction = ins;
    bus.mem_ack = ack;
    bus.branch_cond = bc;
    @(posedge clock);
    #1;
  endtask

  // Issue one instruction with a given stall count, ack delay and branch flag;
  // inputs outside the cycles that matter are randomised.
  task automatic applyStimulus(input int op, input int stalls, input int n, input logic bc,
                               input logic fault);
    exp_q.push_back(model(op, stalls + pre_stalls, n, bc, fault));
    pre_stalls = 0;
    repeat (stalls) step(1'b0, rop(), rbit(), rbit());
    step(1'b1, rop(), rbit(), rbit());
    step(rbit(), OP_W'(op), rbit(), rbit());
    step(rbit(), rop(), rbit(), rbit());
    if (!(op <= 7 || op == 15) || op == 15) return;
    if (op == 5 || op == 6) begin
      if (fault) begin
        repeat (TIMEOUT) step(rbit(), rop(), 1'b0, rbit());
        return;
      end
      for (int i = 1; i <= n; i++) step(rbit(), rop(), (i == n), rbit());
    end
    step(rbit(), rop(), rbit(), bc);
  endtask

  // Hold reset for a cycle, then release with run low for one FETCH cycle.
  task automatic doReset(input string tag);
    reset = 1'b1;
    bus.run = 1'b1;
    bus.instruction = rop();
    @(negedge clock);
    checkOutput({tag, ".outputs_in_reset"}, out_vec(), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.run = 1'b0;
    @(negedge clock);
    checkOutput({tag, ".state_after_reset"}, int'(bus.state_o), 0);
    checkOutput({tag, ".halted_after_reset"}, int'(bus.halted), 0);
    checkOutput({tag, ".timeout_after_reset"}, int'(bus.mem_timeout), 0);
    @(posedge clock);
    #1;
    pre_stalls = 1;
  endtask

  task automatic compareRecord(input rec_t e, input rec_t o, input int idx);
    string p;
    p = $sformatf("rec%0d", idx);
    checkOutput({p, ".alu_op"},      o.op,           e.op);
    checkOutput({p, ".stalls"},      o.stalls,       e.stalls);
    checkOutput({p, ".latency"},     o.latency,      e.latency);
    checkOutput({p, ".next_ins"},    o.next_ins_c,   e.next_ins_c);
    checkOutput({p, ".immediate"},   o.imm_c,        e.imm_c);
    checkOutput({p, ".mem_req"},     o.mem_req_c,    e.mem_req_c);
    checkOutput({p, ".mem_write"},   o.mem_write_c,  e.mem_write_c);
    checkOutput({p, ".mem_to_reg"},  o.mem_to_reg_c, e.mem_to_reg_c);
    checkOutput({p, ".reg_write"},   o.reg_write_c,  e.reg_write_c);
    checkOutput({p, ".pc_load"},     o.pc_load_c,    e.pc_load_c);
    checkOutput({p, ".illegal_op"},  o.illegal_c,    e.illegal_c);
    checkOutput({p, ".halted"},      o.halted_end,   e.halted_end);
    checkOutput({p, ".mem_timeout"}, o.timeout_end,  e.timeout_end);
  endtask

  // Monitor: an instruction starts on next_ins and ends in WRITEBACK, on an
  // illegal_op pulse, or on entering HALTED/FAULT; reset abandons it.
  initial begin
    bit   in_rec;
    int   stall_acc;
    rec_t obs;
    in_rec = 0;
    stall_acc = 0;
    rec_idx = 0;
    obs = '{default: 0};
    forever begin
      @(negedge clock);
      if (reset) begin
        in_rec = 0;
        stall_acc = 0;
      end else begin
        if (!in_rec) begin
          if (bus.next_ins) begin
            in_rec = 1;
            obs = '{default: 0};
            obs.stalls = stall_acc;
            stall_acc = 0;
          end else if (bus.state_o == 3'd0) begin
            stall_acc++;
          end
        end
        if (in_rec) begin
          obs.latency++;
          obs.next_ins_c   += int'(bus.next_ins);
          obs.imm_c        += int'(bus.immediate);
          obs.mem_req_c    += int'(bus.mem_req);
          obs.mem_write_c  += int'(bus.mem_write);
          obs.mem_to_reg_c += int'(bus.mem_to_reg);
          obs.reg_write_c  += int'(bus.reg_write);
          obs.pc_load_c    += int'(bus.pc_load);
          obs.illegal_c    += int'(bus.illegal_op);
          if (bus.state_o == 3'd4 || bus.illegal_op || bus.halted) begin
            in_rec = 0;
            obs.op = int'(bus.alu_op);
            obs.halted_end = int'(bus.halted);
            obs.timeout_end = int'(bus.mem_timeout);
            if (exp_q.size() == 0) begin
              checkOutput($sformatf("rec%0d.unexpected", rec_idx), 1, 0);
            end else begin
              compareRecord(exp_q.pop_front(), obs, rec_idx);
            end
            rec_idx++;
          end
        end
      end
    end
  end

  // Directed scenarios, a randomised run, then fault/halt/reset corners.
  initial begin
    int op;
    checks = 0;
    failures = 0;
    pre_stalls = 0;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.instruction = '0;
    bus.mem_ack = 1'b0;
    bus.branch_cond = 1'b0;
    @(posedge clock);
    #1;
    doReset("init");

    applyStimulus(0, 0, 1, 1'b0, 1'b0);
    applyStimulus(5, 0, 3, 1'b0, 1'b0);
    applyStimulus(6, 0, 3, 1'b0, 1'b0);
    applyStimulus(7, 0, 1, 1'b1, 1'b0);
    applyStimulus(7, 0, 1, 1'b0, 1'b0);
    applyStimulus(9, 0, 1, 1'b0, 1'b0);
    applyStimulus(6, 0, TIMEOUT, 1'b1, 1'b0);
    applyStimulus(1, 5, 1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 14);
      applyStimulus(op, $urandom_range(0, 3), $urandom_range(1, 6), rbit(), 1'b0);
    end

    applyStimulus(6, 1, 1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.run = 1'b1;
      @(negedge clock);
      checkOutput($sformatf("fault_hold%0d.halted", i), int'(bus.halted), 1);
      checkOutput($sformatf("fault_hold%0d.next_ins", i), int'(bus.next_ins), 0);
      checkOutput($sformatf("fault_hold%0d.mem_timeout", i), int'(bus.mem_timeout), 1);
      @(posedge clock);
      #1;
    end
    doReset("post_fault");

    applyStimulus(15, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.run = 1'b1;
      @(negedge clock);
      checkOutput($sformatf("halt_hold%0d.halted", i), int'(bus.halted), 1);
      checkOutput($sformatf("halt_hold%0d.state", i), int'(bus.state_o), 5);
      @(posedge clock);
      #1;
    end
    doReset("post_halt");

    // LD abandoned by reset during its first MEM cycle; nothing is expected.
    step(1'b1, rop(), 1'b0, 1'b0);
    step(1'b1, OP_W'(5), 1'b0, 1'b0);
    step(1'b1, rop(), 1'b0, 1'b0);
    bus.mem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_in_mem.mem_req", int'(bus.mem_req), 0);
    checkOutput("reset_in_mem.outputs", out_vec(), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.run = 1'b0;
    @(negedge clock);
    checkOutput("reset_in_mem.state", int'(bus.state_o), 0);
    checkOutput("reset_in_mem.mem_req_after", int'(bus.mem_req), 0);
    @(posedge clock);
    #1;
    pre_stalls = 1;

    applyStimulus(2, 0, 1, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    checkOutput("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
